// File: rtl/cr_huf_compPKG.sv
// Shared widths and FSM encoding for the Huffman LUT write packer.
`include "cr_huf_comp.vh"

package cr_huf_compPKG;

    localparam int unsigned HDR_W      = `CREOLE_HC_HDR_WIDTH;
    localparam int unsigned BITS_W     = `CREOLE_HC_SYMB_MAX_BITS_WIDTH;
    localparam int unsigned SEQID_W    = `CREOLE_HC_SEQID_WIDTH;
    localparam int unsigned PAIR_CNT_W = `CREOLE_HC_SHORT_SYM_ADDR_WIDTH - 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EVEN,
        ST_ODD,
        ST_FLUSH,
        ST_DONE
    } lut_wr_state_e;

endpackage

// File: rtl/cr_huf_comp.vh
// Width macros shared by the Huffman compressor LUT path.
`ifndef CR_HUF_COMP_VH
`define CR_HUF_COMP_VH

`define CREOLE_HC_HDR_WIDTH             16
`define CREOLE_HC_SYMB_MAX_BITS_WIDTH   16
`define CREOLE_HC_SEQID_WIDTH           8
`define CREOLE_HC_SHORT_SYM_ADDR_WIDTH  10

`endif

// File: rtl/cr_huf_comp_size_acc.sv
// Single size accumulator; saturates at all-ones when CR_HUF_COMP_LUT_WR_PACK_SAT_EN
// is defined, otherwise wraps modulo 2^BITS_W.
module cr_huf_comp_size_acc
    import cr_huf_compPKG::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              add_en,
    input  logic [BITS_W-1:0] add_val,
    output logic [BITS_W-1:0] sum
);

    logic [BITS_W-1:0] sum_q;
    logic [BITS_W-1:0] sum_d;
    logic [BITS_W-1:0] base;
`ifdef CR_HUF_COMP_LUT_WR_PACK_SAT_EN
    logic [BITS_W:0]   total;
`endif

    // A clear on the same beat as an add starts the new table from that beat's value.
    always_comb begin
        base  = clr ? '0 : sum_q;
        sum_d = base;
`ifdef CR_HUF_COMP_LUT_WR_PACK_SAT_EN
        total = {1'b0, base} + {1'b0, add_val};
        if (add_en) begin
            sum_d = total[BITS_W] ? '1 : total[BITS_W-1:0];
        end
`else
        if (add_en) begin
            sum_d = base + add_val;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;

endmodule

// File: rtl/cr_huf_comp_lut_wr_pack.sv
// Packs per-symbol LUT entries into even/odd pair writes and reports table sizes.
// Optional: CR_HUF_COMP_LUT_WR_PACK_SAT_EN makes the size accumulators saturate.
module cr_huf_comp_lut_wr_pack
    import cr_huf_compPKG::*;
#(
    parameter int unsigned N_SYMBOLS = 576
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [HDR_W-1:0]      in_data,
    input  logic                  in_last,
    input  logic [BITS_W-1:0]     in_ret_bits,
    input  logic [BITS_W-1:0]     in_pre_bits,
    input  logic [BITS_W-1:0]     in_sim_bits,
    input  logic [SEQID_W-1:0]    in_seq_id,
    input  logic                  lut_hw_full,
    output logic                  hw_lut_wr,
    output logic [1:0]            hw_lut_wr_val,
    output logic                  hw_lut_wr_odd,
    output logic [2*HDR_W-1:0]    hw_lut_wr_data,
    output logic [PAIR_CNT_W-1:0] hw_lut_wr_addr,
    output logic                  hw_lut_wr_done,
    output logic                  hw_lut_sizes_val,
    output logic [BITS_W-1:0]     hw_lut_ret_size,
    output logic [BITS_W-1:0]     hw_lut_pre_size,
    output logic [BITS_W-1:0]     hw_lut_sim_size,
    output logic [SEQID_W-1:0]    hw_lut_seq_id,
    output logic                  ovfl_err
);

    localparam int unsigned CNT_W = $clog2(N_SYMBOLS + 1);

    lut_wr_state_e           state_q, state_d;
    logic [HDR_W-1:0]        low_q, low_d;
    logic [PAIR_CNT_W-1:0]   pair_cnt_q, pair_cnt_d;
    logic [CNT_W-1:0]        sym_cnt_q, sym_cnt_d;
    logic [SEQID_W-1:0]      seq_id_q, seq_id_d;
    logic                    ovfl_q, ovfl_d;
    logic                    wr_q, wr_d;
    logic [1:0]              wr_val_q, wr_val_d;
    logic                    wr_odd_q, wr_odd_d;
    logic [2*HDR_W-1:0]      wr_data_q, wr_data_d;
    logic [PAIR_CNT_W-1:0]   wr_addr_q, wr_addr_d;
    logic                    done_q, done_d;

    logic rdy_c;
    logic accept;
    logic drop;
    logic acc_clr;
    logic acc_en;

    // Mid-table the producer is never stalled; only a new table waits for LUT space.
    always_comb begin
        rdy_c = 1'b0;
        unique case (state_q)
            ST_IDLE:        rdy_c = ~lut_hw_full;
            ST_EVEN, ST_ODD: rdy_c = 1'b1;
            default:        rdy_c = 1'b0;
        endcase
    end

    assign in_rdy = rst_n & rdy_c;
    assign accept = in_vld & in_rdy;
    assign drop   = ((state_q == ST_EVEN) || (state_q == ST_ODD)) &&
                    (sym_cnt_q == CNT_W'(N_SYMBOLS));

    always_comb begin
        state_d    = state_q;
        low_d      = low_q;
        pair_cnt_d = pair_cnt_q;
        sym_cnt_d  = sym_cnt_q;
        seq_id_d   = seq_id_q;
        ovfl_d     = ovfl_q;
        wr_d       = 1'b0;
        wr_val_d   = 2'b00;
        wr_odd_d   = 1'b0;
        wr_data_d  = wr_data_q;
        wr_addr_d  = wr_addr_q;
        done_d     = 1'b0;
        acc_clr    = 1'b0;
        acc_en     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    acc_clr    = 1'b1;
                    acc_en     = 1'b1;
                    low_d      = in_data;
                    sym_cnt_d  = CNT_W'(1);
                    pair_cnt_d = '0;
                    seq_id_d   = in_seq_id;
                    if (in_last) begin
                        state_d   = ST_FLUSH;
                        wr_d      = 1'b1;
                        wr_val_d  = 2'b01;
                        wr_odd_d  = 1'b1;
                        wr_data_d = {HDR_W'(0), in_data};
                        wr_addr_d = '0;
                    end else begin
                        state_d = ST_ODD;
                    end
                end
            end
            ST_EVEN, ST_ODD: begin
                if (accept && drop) begin
                    // Overflow beats are swallowed; a held even entry still gets flushed.
                    ovfl_d = 1'b1;
                    if (in_last) begin
                        if (state_q == ST_ODD) begin
                            state_d   = ST_FLUSH;
                            wr_d      = 1'b1;
                            wr_val_d  = 2'b01;
                            wr_odd_d  = 1'b1;
                            wr_data_d = {HDR_W'(0), low_q};
                            wr_addr_d = pair_cnt_q;
                        end else begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end else if (accept) begin
                    acc_en    = 1'b1;
                    sym_cnt_d = sym_cnt_q + CNT_W'(1);
                    if (state_q == ST_EVEN) begin
                        low_d = in_data;
                        if (in_last) begin
                            state_d   = ST_FLUSH;
                            wr_d      = 1'b1;
                            wr_val_d  = 2'b01;
                            wr_odd_d  = 1'b1;
                            wr_data_d = {HDR_W'(0), in_data};
                            wr_addr_d = pair_cnt_q;
                        end else begin
                            state_d = ST_ODD;
                        end
                    end else begin
                        wr_d       = 1'b1;
                        wr_val_d   = 2'b11;
                        wr_data_d  = {in_data, low_q};
                        wr_addr_d  = pair_cnt_q;
                        pair_cnt_d = pair_cnt_q + PAIR_CNT_W'(1);
                        state_d    = in_last ? ST_DONE : ST_EVEN;
                        done_d     = in_last;
                    end
                end
            end
            ST_FLUSH: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            low_q      <= '0;
            pair_cnt_q <= '0;
            sym_cnt_q  <= '0;
            seq_id_q   <= '0;
            ovfl_q     <= 1'b0;
            wr_q       <= 1'b0;
            wr_val_q   <= 2'b00;
            wr_odd_q   <= 1'b0;
            wr_data_q  <= '0;
            wr_addr_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            low_q      <= low_d;
            pair_cnt_q <= pair_cnt_d;
            sym_cnt_q  <= sym_cnt_d;
            seq_id_q   <= seq_id_d;
            ovfl_q     <= ovfl_d;
            wr_q       <= wr_d;
            wr_val_q   <= wr_val_d;
            wr_odd_q   <= wr_odd_d;
            wr_data_q  <= wr_data_d;
            wr_addr_q  <= wr_addr_d;
            done_q     <= done_d;
        end
    end

    cr_huf_comp_size_acc u_ret_acc (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (acc_clr),
        .add_en  (acc_en),
        .add_val (in_ret_bits),
        .sum     (hw_lut_ret_size)
    );

    cr_huf_comp_size_acc u_pre_acc (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (acc_clr),
        .add_en  (acc_en),
        .add_val (in_pre_bits),
        .sum     (hw_lut_pre_size)
    );

    cr_huf_comp_size_acc u_sim_acc (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (acc_clr),
        .add_en  (acc_en),
        .add_val (in_sim_bits),
        .sum     (hw_lut_sim_size)
    );

    assign hw_lut_wr        = wr_q;
    assign hw_lut_wr_val    = wr_val_q;
    assign hw_lut_wr_odd    = wr_odd_q;
    assign hw_lut_wr_data   = wr_data_q;
    assign hw_lut_wr_addr   = wr_addr_q;
    assign hw_lut_wr_done   = done_q;
    assign hw_lut_sizes_val = done_q;
    assign hw_lut_seq_id    = seq_id_q;
    assign ovfl_err         = ovfl_q;

endmodule

// File: tb/tb_cr_huf_comp_lut_wr_pack.sv
// Directed bench for the LUT write packer: pairing, flush, back-pressure, overflow, sizes, reset.
module tb_cr_huf_comp_lut_wr_pack;
    import cr_huf_compPKG::*;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  in_vld;
    logic                  in_rdy;
    logic [HDR_W-1:0]      in_data;
    logic                  in_last;
    logic [BITS_W-1:0]     in_ret_bits, in_pre_bits, in_sim_bits;
    logic [SEQID_W-1:0]    in_seq_id;
    logic                  lut_hw_full;
    logic                  hw_lut_wr;
    logic [1:0]            hw_lut_wr_val;
    logic                  hw_lut_wr_odd;
    logic [2*HDR_W-1:0]    hw_lut_wr_data;
    logic [PAIR_CNT_W-1:0] hw_lut_wr_addr;
    logic                  hw_lut_wr_done;
    logic                  hw_lut_sizes_val;
    logic [BITS_W-1:0]     hw_lut_ret_size, hw_lut_pre_size, hw_lut_sim_size;
    logic [SEQID_W-1:0]    hw_lut_seq_id;
    logic                  ovfl_err;

    int checks   = 0;
    int failures = 0;

    int unsigned           wr_total   = 0;
    int unsigned           done_total = 0;
    logic [PAIR_CNT_W-1:0] max_addr   = '0;
    logic [2*HDR_W-1:0]    last_data  = '0;

    always #5 clk = ~clk;

    cr_huf_comp_lut_wr_pack #(.N_SYMBOLS(576)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_vld           (in_vld),
        .in_rdy           (in_rdy),
        .in_data          (in_data),
        .in_last          (in_last),
        .in_ret_bits      (in_ret_bits),
        .in_pre_bits      (in_pre_bits),
        .in_sim_bits      (in_sim_bits),
        .in_seq_id        (in_seq_id),
        .lut_hw_full      (lut_hw_full),
        .hw_lut_wr        (hw_lut_wr),
        .hw_lut_wr_val    (hw_lut_wr_val),
        .hw_lut_wr_odd    (hw_lut_wr_odd),
        .hw_lut_wr_data   (hw_lut_wr_data),
        .hw_lut_wr_addr   (hw_lut_wr_addr),
        .hw_lut_wr_done   (hw_lut_wr_done),
        .hw_lut_sizes_val (hw_lut_sizes_val),
        .hw_lut_ret_size  (hw_lut_ret_size),
        .hw_lut_pre_size  (hw_lut_pre_size),
        .hw_lut_sim_size  (hw_lut_sim_size),
        .hw_lut_seq_id    (hw_lut_seq_id),
        .ovfl_err         (ovfl_err)
    );

    // Write/done strobes are single-cycle, so sampling on the falling edge sees each once.
    always @(negedge clk) begin
        if (hw_lut_wr) begin
            wr_total  <= wr_total + 1;
            last_data <= hw_lut_wr_data;
            if (hw_lut_wr_addr > max_addr) max_addr <= hw_lut_wr_addr;
        end
        if (hw_lut_wr_done) done_total <= done_total + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One beat: present on the falling edge, confirm ready, let the rising edge take it.
    task automatic send(input logic [HDR_W-1:0] d, input logic last,
                        input logic [BITS_W-1:0] r, input logic [BITS_W-1:0] p,
                        input logic [BITS_W-1:0] s, input logic [SEQID_W-1:0] sq);
        @(negedge clk);
        in_vld      = 1'b1;
        in_data     = d;
        in_last     = last;
        in_ret_bits = r;
        in_pre_bits = p;
        in_sim_bits = s;
        in_seq_id   = sq;
        #1;
        chk("in_rdy_beat", in_rdy, 1);
        @(posedge clk);
        #1;
        in_vld  = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic chk_wr(input string tag, input logic [1:0] val, input logic odd,
                          input logic [2*HDR_W-1:0] data, input logic [PAIR_CNT_W-1:0] addr);
        chk({tag, "_wr"}, hw_lut_wr, 1);
        chk({tag, "_val"}, hw_lut_wr_val, val);
        chk({tag, "_odd"}, hw_lut_wr_odd, odd);
        chk({tag, "_data"}, hw_lut_wr_data, data);
        chk({tag, "_addr"}, hw_lut_wr_addr, addr);
    endtask

    task automatic chk_done(input string tag, input logic [BITS_W-1:0] r, input logic [BITS_W-1:0] p,
                            input logic [BITS_W-1:0] s, input logic [SEQID_W-1:0] sq);
        chk({tag, "_done"}, hw_lut_wr_done, 1);
        chk({tag, "_sval"}, hw_lut_sizes_val, 1);
        chk({tag, "_ret"}, hw_lut_ret_size, r);
        chk({tag, "_pre"}, hw_lut_pre_size, p);
        chk({tag, "_sim"}, hw_lut_sim_size, s);
        chk({tag, "_seq"}, hw_lut_seq_id, sq);
        chk({tag, "_rdy_done"}, in_rdy, 0);
    endtask

    initial begin
        int unsigned wr_before;
        int unsigned done_before;
        logic [BITS_W-1:0] exp_ret, exp_pre;

        rst_n       = 1'b0;
        in_vld      = 1'b1;
        in_data     = '0;
        in_last     = 1'b0;
        in_ret_bits = '0;
        in_pre_bits = '0;
        in_sim_bits = '0;
        in_seq_id   = '0;
        lut_hw_full = 1'b0;

        // Reset state
        #3;
        chk("rst_rdy", in_rdy, 0);
        chk("rst_wr", hw_lut_wr, 0);
        chk("rst_done", hw_lut_wr_done, 0);
        chk("rst_data", hw_lut_wr_data, 0);
        chk("rst_addr", hw_lut_wr_addr, 0);
        chk("rst_ret", hw_lut_ret_size, 0);
        chk("rst_seq", hw_lut_seq_id, 0);
        chk("rst_ovfl", ovfl_err, 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        in_vld = 1'b0;
        rst_n  = 1'b1;

        // Four symbols: two full pairs, done coincides with the last pair
        send(16'h01A0, 1'b0, 1, 1, 1, 8'h05);
        chk("a0_nowr", hw_lut_wr, 0);
        send(16'h01A1, 1'b0, 1, 1, 1, 8'h05);
        chk_wr("a1", 2'b11, 1'b0, 32'h01A1_01A0, 0);
        chk("a1_nodone", hw_lut_wr_done, 0);
        send(16'h01A2, 1'b0, 1, 1, 1, 8'h05);
        chk("a2_nowr", hw_lut_wr, 0);
        send(16'h01A3, 1'b1, 1, 1, 1, 8'h05);
        chk_wr("a3", 2'b11, 1'b0, 32'h01A3_01A2, 1);
        chk_done("a3", 4, 4, 4, 8'h05);
        tick();
        chk("a_post_done", hw_lut_wr_done, 0);
        chk("a_post_wr", hw_lut_wr, 0);
        chk("a_hold_ret", hw_lut_ret_size, 4);
        chk("a_hold_seq", hw_lut_seq_id, 8'h05);
        chk("a_ovfl", ovfl_err, 0);

        // Three symbols: pair, then flush of the lone even entry, then done
        send(16'h0E00, 1'b0, 2, 3, 4, 8'h09);
        send(16'h0E01, 1'b0, 2, 3, 4, 8'h09);
        chk_wr("b1", 2'b11, 1'b0, 32'h0E01_0E00, 0);
        send(16'h0E02, 1'b1, 2, 3, 4, 8'h09);
        chk_wr("b2", 2'b01, 1'b1, 32'h0000_0E02, 1);
        chk("b2_nodone", hw_lut_wr_done, 0);
        chk("b2_rdy_flush", in_rdy, 0);
        tick();
        chk("b3_nowr", hw_lut_wr, 0);
        chk_done("b3", 6, 9, 12, 8'h09);
        tick();

        // Single symbol table
        send(16'h0F0F, 1'b1, 7, 8, 9, 8'h03);
        chk_wr("c0", 2'b01, 1'b1, 32'h0000_0F0F, 0);
        tick();
        chk_done("c1", 7, 8, 9, 8'h03);
        tick();

        // Back-pressure in IDLE, ignored mid-table
        wr_before = wr_total;
        @(negedge clk);
        lut_hw_full = 1'b1;
        in_vld      = 1'b1;
        in_data     = 16'h0D00;
        in_ret_bits = 1;
        in_pre_bits = 1;
        in_sim_bits = 1;
        in_seq_id   = 8'h22;
        #1;
        chk("d_full_rdy", in_rdy, 0);
        tick();
        tick();
        chk("d_full_nowr", wr_total - wr_before, 0);
        @(negedge clk);
        lut_hw_full = 1'b0;
        #1;
        chk("d_drop_rdy", in_rdy, 1);
        @(posedge clk);
        #1;
        in_vld      = 1'b0;
        lut_hw_full = 1'b1;
        #1;
        chk("d_mid_rdy", in_rdy, 1);
        send(16'h0D01, 1'b1, 2, 2, 2, 8'h99);
        chk_wr("d1", 2'b11, 1'b0, 32'h0D01_0D00, 0);
        chk_done("d1", 3, 3, 3, 8'h22);
        lut_hw_full = 1'b0;
        tick();

        // 577 symbols into a 576-entry table
        wr_before = wr_total;
        for (int i = 0; i < 577; i++) begin
            send(HDR_W'(i), (i == 576), 1, 1, 1, 8'h40);
            if (i == 575) chk("e_ovfl_pre", ovfl_err, 0);
        end
        chk("e_ovfl", ovfl_err, 1);
        chk("e_nowr_drop", hw_lut_wr, 0);
        chk_done("e", 576, 576, 576, 8'h40);
        tick();
        chk("e_wr_count", wr_total - wr_before, 288);
        chk("e_max_addr", max_addr, 287);
        chk("e_last_data", last_data, 32'h023F_023E);

        // Size accumulation near the top of the range
        send(16'h0500, 1'b0, 16'hFFF0, 16'h8000, 16'h0001, 8'h07);
        send(16'h0501, 1'b1, 16'h0020, 16'h8000, 16'h0002, 8'h07);
`ifdef CR_HUF_COMP_LUT_WR_PACK_SAT_EN
        exp_ret = 16'hFFFF;
        exp_pre = 16'hFFFF;
`else
        exp_ret = 16'h0010;
        exp_pre = 16'h0000;
`endif
        chk_wr("f1", 2'b11, 1'b0, 32'h0501_0500, 0);
        chk_done("f1", exp_ret, exp_pre, 3, 8'h07);
        chk("f_ovfl_sticky", ovfl_err, 1);
        tick();

        // Reset in the middle of a table
        done_before = done_total;
        send(16'h0700, 1'b0, 5, 5, 5, 8'h11);
        send(16'h0701, 1'b0, 5, 5, 5, 8'h11);
        chk_wr("g1", 2'b11, 1'b0, 32'h0701_0700, 0);
        send(16'h0702, 1'b0, 5, 5, 5, 8'h11);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("g_rst_rdy", in_rdy, 0);
        chk("g_rst_wr", hw_lut_wr, 0);
        chk("g_rst_data", hw_lut_wr_data, 0);
        chk("g_rst_ret", hw_lut_ret_size, 0);
        chk("g_rst_seq", hw_lut_seq_id, 0);
        chk("g_rst_ovfl", ovfl_err, 0);
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        chk("g_no_done", done_total - done_before, 0);
        chk("g_idle_rdy", in_rdy, 1);
        chk("g_idle_wr", hw_lut_wr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cr_huf_comp_lut_wr_pack.md
CR_HUF_COMP_LUT_WR_PACK -- requirements
Module: cr_huf_comp_lut_wr_pack

Interface
REQ-001 SHALL have parameter N_SYMBOLS, default 576, max symbols per table.
REQ-002 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- in_vld  in  1  symbol entry valid
- in_rdy  out  1  symbol entry accepted when in_vld&in_rdy
- in_data  in  `CREOLE_HC_HDR_WIDTH  per-symbol LUT entry
- in_last  in  1  final symbol of table
- in_ret_bits, in_pre_bits, in_sim_bits  in  `CREOLE_HC_SYMB_MAX_BITS_WIDTH each  per-symbol size contributions
- in_seq_id  in  `CREOLE_HC_SEQID_WIDTH  table sequence id, sampled on first beat
- lut_hw_full  in  1  LUT twin buffer full
- hw_lut_wr  out  1  pair write strobe
- hw_lut_wr_val  out  2  [0]=low half valid, [1]=high half valid
- hw_lut_wr_odd  out  1  final write holds a single entry
- hw_lut_wr_data  out  2*`CREOLE_HC_HDR_WIDTH  {odd symbol, even symbol}
- hw_lut_wr_addr  out  `CREOLE_HC_SHORT_SYM_ADDR_WIDTH-1  pair index
- hw_lut_wr_done  out  1  table-complete pulse
- hw_lut_sizes_val  out  1  sizes valid pulse
- hw_lut_ret_size, hw_lut_pre_size, hw_lut_sim_size  out  `CREOLE_HC_SYMB_MAX_BITS_WIDTH each  accumulated sizes
- hw_lut_seq_id  out  `CREOLE_HC_SEQID_WIDTH  table id
- ovfl_err  out  1  sticky: more than N_SYMBOLS symbols in one table

Function
REQ-003 SHALL implement FSM IDLE, EVEN, ODD, FLUSH, DONE.
REQ-004 IDLE: in_rdy = ~lut_hw_full; an accepted beat moves to ODD, clears accumulators, latches in_seq_id.
REQ-005 Even-index symbol SHALL be held in a low-half register; no write is issued. EVEN→ODD on accept.
REQ-006 On accepting an odd-index symbol:
- following cycle: hw_lut_wr=1, hw_lut_wr_val=2'b11, data={new, held}, addr=pair count;
- pair count increments; state →EVEN.
REQ-007 in_last on an even-index symbol SHALL go to FLUSH. FLUSH issues one write: val=2'b01, wr_odd=1, high half zero.
REQ-008 in_last on an odd-index symbol SHALL go directly to DONE after its pair write.
REQ-009 DONE (one cycle):
- hw_lut_wr_done=1 and hw_lut_sizes_val=1 with final sizes;
- sizes and seq_id outputs hold until the next table starts;
- →IDLE.
REQ-010 in_rdy SHALL be 0 in FLUSH and DONE, and 1 in EVEN/ODD (lut_hw_full is ignored mid-table).
REQ-011 Each accepted beat SHALL add in_*_bits to the three accumulators; the last beat is included before DONE.
REQ-012 Write latency SHALL be exactly 1 cycle after accept; at most one hw_lut_wr per cycle; back-to-back pairs at full rate.
REQ-013 On a beat beyond N_SYMBOLS:
- the beat is accepted and dropped; no write, no accumulation;
- ovfl_err set, cleared only by reset;
- in_last is still honoured.
REQ-014 Pair count SHALL wrap to 0 only at a new table; address never exceeds (N_SYMBOLS/2)-1.

Reset
REQ-015 Asynchronous assert, synchronous deassert (external). State and outputs at reset:
- FSM=IDLE, all strobes 0, data/addr/sizes/seq_id 0, ovfl_err 0, accumulators 0.
REQ-016 in_rdy SHALL be 0 while rst_n=0.
REQ-017 Reset mid-table SHALL discard the partial table; no wr_done is issued.

Configuration
REQ-018 Macro CR_HUF_COMP_LUT_WR_PACK_SAT_EN:
- defined: accumulators saturate at all-ones;
- undefined: accumulators wrap modulo 2^`CREOLE_HC_SYMB_MAX_BITS_WIDTH.

Structure
REQ-019 FSM state enum and pair-count width constant SHALL reside in cr_huf_compPKG; widths come from cr_huf_comp.vh macros.
REQ-020 One sub-module, cr_huf_comp_size_acc: a single accumulator honouring REQ-018, instantiated three times.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- 4 symbols D0..D3, bits 1 each, last on D3 → writes addr0 {D1,D0} and addr1 {D3,D2} with val 11; DONE with sizes 4/4/4, wr_done+sizes_val same cycle.
- 3 symbols → addr0 pair write, then addr1 val=01 odd=1 high=0, then DONE.
- 1 symbol with last → FLUSH write addr0 odd=1, DONE; sizes equal that symbol's bits.
- lut_hw_full=1 in IDLE with in_vld=1 → in_rdy=0, no writes; drop full → first beat accepted next cycle.
- 577 symbols, N_SYMBOLS=576 → 288 writes, ovfl_err=1, DONE still issued.
- Sizes near max with macro defined → all-ones; without → wrapped value; reset asserted mid-table → outputs zero, no wr_done.
